// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level sizing and output
// conditioning (arithmetic scale, then clamp or wrap).
package adder_tree_pkg;

    // Widest accumulator value the output conditioning accepts.
    localparam int SCALE_MAX_W = 64;

    function automatic int tree_stages(input int n);
        return $clog2(n);
    endfunction

    // Output width of tree level l (level 0 takes IN_WIDTH-wide operands).
    function automatic int level_width(input int in_w, input int l);
        return in_w + l + 1;
    endfunction

    // Returns {sat, y}; the caller keeps the low OUT_WIDTH bits of y.
    function automatic logic [SCALE_MAX_W:0] scale_sat(
        input logic signed [SCALE_MAX_W-1:0] x,
        input int                            scale,
        input int                            out_w,
        input bit                            saturate
    );
        logic signed [SCALE_MAX_W-1:0] y;
        logic signed [SCALE_MAX_W-1:0] hi;
        logic signed [SCALE_MAX_W-1:0] lo;
        logic                          sat;
        y   = x >>> scale;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = 1'b0;
        if (saturate) begin
            if (y > hi) begin
                y   = hi;
                sat = 1'b1;
            end else if (y < lo) begin
                y   = lo;
                sat = 1'b1;
            end
        end
        return {sat, y};
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_acc_level.sv
// One registered reduction level: N signed operands of width W become N/2
// operands of width W+1. Flags ride along; everything holds while en=0.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [N*W-1:0]                  in_data,
    output logic                            out_valid,
    output logic                            out_first,
    output logic                            out_last,
    output logic [(N/2)*level_width(W,0)-1:0] out_data
);

    localparam int WO = level_width(W, 0);

    logic [(N/2)*WO-1:0] sum;

    always_comb begin
        sum = '0;
        for (int k = 0; k < N/2; k++) begin
            sum[k*WO +: WO] = WO'($signed(in_data[(2*k)*W +: W]))
                            + WO'($signed(in_data[(2*k+1)*W +: W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_first <= in_first;
            out_last  <= in_last;
            out_data  <= sum;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree_acc.sv
// N-operand pipelined signed adder tree feeding a running-sum accumulator
// with scaled, saturating (or wrapping) output and valid/ready on both sides.
module pipelined_adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_GUARD = 8,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(N_IN) + ACC_GUARD,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SCALE = 0,
    parameter int SATURATE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*IN_WIDTH-1:0] in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_sat
);

    localparam int STAGES = tree_stages(N_IN);
    localparam int SUM_W  = IN_WIDTH + STAGES;

    logic                        adv;
    logic [STAGES:0]             stg_v;
    logic [STAGES:0]             stg_f;
    logic [STAGES:0]             stg_l;
    logic [SUM_W-1:0]            tree_sum;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [SCALE_MAX_W:0]        cond;

    // One global advance: the whole pipe stalls together, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign stg_v[0] = in_valid;
    assign stg_f[0] = in_first;
    assign stg_l[0] = in_last;

    for (genvar l = 0; l < STAGES; l++) begin : g_lvl
        localparam int NI = N_IN >> l;
        localparam int WI = IN_WIDTH + l;
        localparam int WO = level_width(IN_WIDTH, l);

        logic [NI*WI-1:0]       lvl_in;
        logic [(NI/2)*WO-1:0]   lvl_out;

        if (l == 0) begin : g_src
            assign lvl_in = in_data;
        end else begin : g_src
            assign lvl_in = g_lvl[l-1].lvl_out;
        end

        adder_tree_level #(
            .N (NI),
            .W (WI)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (stg_v[l]),
            .in_first  (stg_f[l]),
            .in_last   (stg_l[l]),
            .in_data   (lvl_in),
            .out_valid (stg_v[l+1]),
            .out_first (stg_f[l+1]),
            .out_last  (stg_l[l+1]),
            .out_data  (lvl_out)
        );
    end

    assign tree_sum = g_lvl[STAGES-1].lvl_out;

    always_comb begin
        sum_ext  = ACC_WIDTH'($signed(tree_sum));
        acc_next = stg_f[STAGES] ? sum_ext : acc + sum_ext;
        cond     = scale_sat(SCALE_MAX_W'(acc_next), OUT_SCALE, OUT_WIDTH, SATURATE != 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            if (stg_v[STAGES]) begin
                if (stg_l[STAGES]) begin
                    out_data  <= cond[OUT_WIDTH-1:0];
                    out_sat   <= cond[SCALE_MAX_W];
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_next;
                    if (out_ready) out_valid <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Bench for pipelined_adder_tree_acc: three configurations share one stimulus
// stream and are scored against a plain-arithmetic accumulation model.
module tb_pipelined_adder_tree_acc;

    localparam int N_IN   = 4;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = IN_W + 2 + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_first, in_last, out_ready;
    logic [N_IN*IN_W-1:0] in_data;
    logic             in_ready0, in_ready1, in_ready2;
    logic             out_valid0, out_valid1, out_valid2;
    logic [OUT_W-1:0] out_data0, out_data1, out_data2;
    logic             out_sat0, out_sat1, out_sat2;

    always #5 clk = ~clk;

    pipelined_adder_tree_acc #(.OUT_SCALE(0), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0));

    pipelined_adder_tree_acc #(.OUT_SCALE(2), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1));

    pipelined_adder_tree_acc #(.OUT_SCALE(0), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_sat(out_sat2));

    typedef struct {
        logic [15:0] d0, d1, d2;
        bit          s0, s1, s2;
    } exp_t;

    exp_t        expq[$];
    longint      macc;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ndeliv = 0;
    bit          ovhist [0:4095];
    bit          last_acc;
    bit          smp_in_ready;
    bit          hold_prev = 1'b0;
    logic [15:0] hold_d0, hold_d1, hold_d2;
    logic [15:0] last_d0, last_d1, last_d2;
    bit          last_s0, last_s1, last_s2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void fmod(input longint x, input int scale, input bit sat,
                                 output logic [15:0] d, output bit s);
        longint y;
        y = x >>> scale;
        s = 1'b0;
        if (sat) begin
            if (y > 32767) begin
                y = 32767;
                s = 1'b1;
            end else if (y < -32768) begin
                y = -32768;
                s = 1'b1;
            end
        end
        d = y[15:0];
    endfunction

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Evaluated just before the rising edge, with this cycle's inputs applied.
    task automatic monitor();
        exp_t   e;
        longint s;
        last_acc     = 1'b0;
        smp_in_ready = in_ready0;
        ovhist[cyc]  = out_valid0;
        if (rst) begin
            expq.delete();
            macc      = 0;
            hold_prev = 1'b0;
            return;
        end
        chk("in_ready0", in_ready0, !out_valid0 || out_ready);
        chk("in_ready_eq", {in_ready1, in_ready2}, {in_ready0, in_ready0});
        if (hold_prev) begin
            chk("hold_valid", out_valid0, 1'b1);
            chk("hold_d0", out_data0, hold_d0);
            chk("hold_d1", out_data1, hold_d1);
            chk("hold_d2", out_data2, hold_d2);
        end
        if (out_valid0 && out_ready) begin
            if (expq.size() == 0) begin
                chk("spurious_out", 1'b1, 1'b0);
            end else begin
                e = expq.pop_front();
                chk("data0", out_data0, e.d0);
                chk("sat0", out_sat0, e.s0);
                chk("data1", out_data1, e.d1);
                chk("sat1", out_sat1, e.s1);
                chk("data2", out_data2, e.d2);
                chk("sat2", out_sat2, e.s2);
                last_d0 = out_data0; last_d1 = out_data1; last_d2 = out_data2;
                last_s0 = out_sat0;  last_s1 = out_sat1;  last_s2 = out_sat2;
                ndeliv++;
            end
        end
        hold_prev = out_valid0 && !out_ready;
        hold_d0 = out_data0; hold_d1 = out_data1; hold_d2 = out_data2;
        if (in_valid && in_ready0) begin
            last_acc = 1'b1;
            s = 0;
            for (int k = 0; k < N_IN; k++) s += longint'($signed(in_data[k*IN_W +: IN_W]));
            macc = in_first ? s : macc + s;
            macc = (macc <<< (64 - ACC_W)) >>> (64 - ACC_W);
            if (in_last) begin
                fmod(macc, 0, 1'b1, e.d0, e.s0);
                fmod(macc, 2, 1'b1, e.d1, e.s1);
                fmod(macc, 0, 1'b0, e.d2, e.s2);
                expq.push_back(e);
                macc = 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit f, input bit l,
                         input logic [63:0] d, input bit ordy);
        rst = r; in_valid = v; in_first = f; in_last = l; in_data = d; out_ready = ordy;
        #1;
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    initial begin
        int c0;
        int sent;
        int stall_until;
        int base;
        bit ordy;
        logic [63:0] rd;

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1;
        macc = 0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("rst_valid", out_valid0, 1'b0);
        chk("rst_data", out_data0, 16'd0);
        chk("rst_sat", out_sat0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("rst_in_ready", smp_in_ready, 1'b1);

        // single beat latency and value
        c0 = cyc;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(1, 2, 3, 4), 1'b1);
        idle(6);
        chk("lat1_c2", ovhist[c0+2], 1'b0);
        chk("lat1_c3", ovhist[c0+3], 1'b1);
        chk("lat1_c4", ovhist[c0+4], 1'b0);
        chk("single_data", last_d0, 16'd10);
        chk("single_sat", last_s0, 1'b0);

        // three-beat accumulation
        c0 = cyc;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, pack(100, 100, 100, 100), 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, pack(100, 100, 100, 100), 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, pack(100, 100, 100, 100), 1'b1);
        idle(6);
        chk("acc3_c3", ovhist[c0+3], 1'b0);
        chk("acc3_c4", ovhist[c0+4], 1'b0);
        chk("acc3_c5", ovhist[c0+5], 1'b1);
        chk("acc3_data", last_d0, 16'd1200);

        // saturation at both rails
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(32767, 32767, 32767, 32767), 1'b1);
        idle(5);
        chk("satp_data", last_d0, 16'h7FFF);
        chk("satp_sat", last_s0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(-32768, -32768, -32768, -32768), 1'b1);
        idle(5);
        chk("satn_data", last_d0, 16'h8000);
        chk("satn_sat", last_s0, 1'b1);

        // scaling (dut1) and wrapping (dut2)
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(7, 0, 0, 0), 1'b1);
        idle(5);
        chk("scale_7", last_d1, 16'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(-1, 0, 0, 0), 1'b1);
        idle(5);
        chk("scale_m1", last_d1, 16'hFFFF);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, pack(32767, 1, 0, 0), 1'b1);
        idle(5);
        chk("wrap_data", last_d2, 16'h8000);
        chk("wrap_sat", last_s2, 1'b0);

        // six results with a five-cycle consumer stall on the first one
        sent = 0;
        stall_until = -1;
        base = ndeliv;
        for (int t = 0; t < 40; t++) begin
            if (stall_until < 0 && out_valid0) stall_until = cyc + 5;
            ordy = !(stall_until >= 0 && cyc < stall_until);
            cycle(1'b0, sent < 6, 1'b1, 1'b1, pack(sent + 1, 2 * sent, 0, -sent), ordy);
            if (last_acc) sent++;
            if (!ordy) chk("stall_in_ready", smp_in_ready, 1'b0);
        end
        chk("stall_sent", sent, 6);
        chk("stall_delivered", ndeliv - base, 6);
        chk("stall_seen", stall_until >= 0, 1'b1);

        // reset in the middle of an accumulation
        cycle(1'b0, 1'b1, 1'b1, 1'b0, pack(5, 5, 5, 5), 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, pack(5, 5, 5, 5), 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, pack(5, 5, 5, 5), 1'b1);
        chk("midrst_valid", out_valid0, 1'b0);
        chk("midrst_data", out_data0, 16'd0);
        chk("midrst_sat", out_sat0, 1'b0);
        base = ndeliv;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, pack(1, 1, 1, 1), 1'b1);
        idle(6);
        chk("midrst_count", ndeliv - base, 1);
        chk("midrst_fresh", last_d0, 16'd4);

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            rd = '0;
            if ($urandom_range(0, 1) == 0) begin
                rd = {$urandom(), $urandom()};
            end else begin
                for (int k = 0; k < N_IN; k++) rd[k*IN_W +: IN_W] = 16'($urandom_range(0, 200) - 100);
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  rd, $urandom_range(0, 3) != 0);
        end
        idle(10);
        chk("drain_empty", expq.size(), 0);
        chk("drain_idle", out_valid0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
